// File: rtl/omem_pkg.sv
// Shared packet layout, opcode helpers and FSM states for the spike residue memory.
package omem_pkg;

    localparam int unsigned PKT_W    = 33;
    localparam int unsigned DATA_W   = 25;
    localparam int unsigned DEST_MSB = 32;
    localparam int unsigned DEST_LSB = 29;
    localparam int unsigned OP_MSB   = 28;
    localparam int unsigned OP_LSB   = 25;
    localparam int unsigned DATA_MSB = 24;
    localparam int unsigned DATA_LSB = 0;

    // Opcode 2k stores for SPE k, 2k+1 requests for SPE k, 15 announces timestep done.
    localparam logic [3:0] OP_TS_DONE = 4'd15;

    typedef struct packed {
        logic [3:0]        dest;
        logic [3:0]        opcode;
        logic [DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_REPLY = 3'd1,
        ST_BCAST = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [3:0] op_store(input logic [2:0] spe);
        return {spe, 1'b0};
    endfunction

    function automatic logic [3:0] op_request(input logic [2:0] spe);
        return {spe, 1'b1};
    endfunction

    function automatic logic [2:0] op_spe(input logic [3:0] op);
        return op[3:1];
    endfunction

    function automatic logic op_is_request(input logic [3:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/omem_bank.sv
// Timestep-banked {spike, residue} storage: one write port, request and drain read ports.
module omem_bank #(
    parameter int unsigned NUM_TS    = 2,
    parameter int unsigned DEPTH     = 441,
    parameter int unsigned SUM_WIDTH = 13,
    parameter int unsigned TS_W      = 2,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [TS_W-1:0]      wr_ts,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [SUM_WIDTH:0]   wr_data,
    input  logic [TS_W-1:0]      rq_ts,
    input  logic [ADDR_W-1:0]    rq_addr,
    output logic [SUM_WIDTH:0]   rq_data,
    input  logic [TS_W-1:0]      dr_ts,
    input  logic [ADDR_W-1:0]    dr_addr,
    output logic [SUM_WIDTH:0]   dr_data
);

    localparam int unsigned ENTRIES = NUM_TS * DEPTH;
    localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [SUM_WIDTH:0] mem [ENTRIES];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rq_idx;
    logic [IDX_W-1:0] dr_idx;
    logic             wr_ok;
    logic             rq_ok;
    logic             dr_ok;

    // Flatten (timestep, address) into one index; out-of-range accesses are ignored.
    always_comb begin
        wr_idx = IDX_W'(32'(wr_ts) * DEPTH + 32'(wr_addr));
        rq_idx = IDX_W'(32'(rq_ts) * DEPTH + 32'(rq_addr));
        dr_idx = IDX_W'(32'(dr_ts) * DEPTH + 32'(dr_addr));
        wr_ok  = (32'(wr_ts) < NUM_TS) && (32'(wr_addr) < DEPTH);
        rq_ok  = (32'(rq_ts) < NUM_TS) && (32'(rq_addr) < DEPTH);
        dr_ok  = (32'(dr_ts) < NUM_TS) && (32'(dr_addr) < DEPTH);
    end

    // Single write port; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Asynchronous read ports; the top registers whatever it consumes.
    always_comb begin
        rq_data = rq_ok ? mem[rq_idx] : '0;
        dr_data = dr_ok ? mem[dr_idx] : '0;
    end

endmodule

// File: rtl/spike_residue_mem.sv
// Output memory for SPE residues/spikes: NoC store/request service, timestep broadcast, spike drain.
module spike_residue_mem
    import omem_pkg::*;
#(
    parameter int unsigned NUM_SPE   = 5,
    parameter int unsigned OUT_DIM   = 21,
    parameter int unsigned NUM_TS    = 2,
    parameter int unsigned SUM_WIDTH = 13,
    parameter int unsigned NUM_NODES = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_in_valid,
    output logic             pkt_in_ready,
    input  logic [PKT_W-1:0] pkt_in_data,
    output logic             pkt_out_valid,
    input  logic             pkt_out_ready,
    output logic [PKT_W-1:0] pkt_out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_ts,
    output logic [11:0]      out_addr,
    output logic             out_spike,
    output logic             out_last,
    output logic             done,
    output logic             err
);

    localparam int unsigned MAP    = OUT_DIM * OUT_DIM;
    localparam int unsigned CNT_W  = $clog2(MAP + 1);
    localparam int unsigned TS_W   = 2;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NPTR   = 8;
    localparam logic [TS_W-1:0] TS_LAST = TS_W'(NUM_TS - 1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] ptr [NPTR];
    logic [3:0]        bcast_idx;
    pkt_t              out_pkt;

    logic [3:0]        in_dest;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        spe;
    logic              spe_ok;
    logic              acc;
    logic              is_store;
    logic              is_req;
    logic              store_ok;
    logic              complete;
    logic              pkt_xfer;
    logic              out_xfer;
    logic              last_beat;
    logic              bcast_last;

    logic [SUM_WIDTH:0]   rq_data;
    logic [SUM_WIDTH:0]   dr_data;
    logic [TS_W-1:0]      dr_ts;
    logic [ADDR_W-1:0]    dr_addr;
    logic [SUM_WIDTH-1:0] reply_res;
    logic                 unused_bits;

    assign pkt_out_data = out_pkt;

    // Ingress decode and handshake qualifiers.
    always_comb begin
        in_dest    = pkt_in_data[DEST_MSB:DEST_LSB];
        in_op      = pkt_in_data[OP_MSB:OP_LSB];
        in_data    = pkt_in_data[DATA_MSB:DATA_LSB];
        spe        = op_spe(in_op);
        spe_ok     = 32'(spe) < NUM_SPE;
        acc        = pkt_in_valid && pkt_in_ready;
        is_store   = acc && spe_ok && (in_op == op_store(spe));
        is_req     = acc && spe_ok && op_is_request(in_op) && (in_op == op_request(spe));
        store_ok   = is_store && (32'(ptr[spe]) < MAP);
        complete   = 32'(cnt) == MAP;
        pkt_xfer   = pkt_out_valid && pkt_out_ready;
        out_xfer   = out_valid && out_ready;
        last_beat  = out_valid && (out_ts == TS_LAST) && (32'(out_addr) == MAP - 1);
        bcast_last = 32'(bcast_idx) == NUM_NODES - 1;
        reply_res  = (ts == '0) ? '0 : rq_data[SUM_WIDTH-1:0];
    end

    // Drain read address: first beat on entry, otherwise the beat after the one presented.
    always_comb begin
        dr_ts   = out_ts;
        dr_addr = out_addr;
        if (!out_valid) begin
            dr_ts   = '0;
            dr_addr = '0;
        end else if (32'(out_addr) == MAP - 1) begin
            dr_ts   = out_ts + TS_W'(1);
            dr_addr = '0;
        end else begin
            dr_addr = out_addr + ADDR_W'(1);
        end
    end

    assign unused_bits = ^{in_dest, in_data, rq_data[SUM_WIDTH], dr_data[SUM_WIDTH-1:0]};

    omem_bank #(
        .NUM_TS    (NUM_TS),
        .DEPTH     (MAP),
        .SUM_WIDTH (SUM_WIDTH),
        .TS_W      (TS_W),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .we      (store_ok),
        .wr_ts   (ts),
        .wr_addr (ptr[spe]),
        .wr_data ({in_data[0], in_data[SUM_WIDTH:1]}),
        .rq_ts   (ts - TS_W'(1)),
        .rq_addr (ptr[spe]),
        .rq_data (rq_data),
        .dr_ts   (dr_ts),
        .dr_addr (dr_addr),
        .dr_data (dr_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and store counter update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (store_ok) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                if (is_req) begin
                    state_nxt = ST_REPLY;
                end else if (complete) begin
                    state_nxt = (ts == TS_LAST) ? ST_DRAIN : ST_BCAST;
                end
            end
            ST_REPLY: begin
                if (pkt_xfer) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_BCAST: begin
                if (pkt_xfer && bcast_last) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                if (out_xfer && last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registered datapath: pointers, timestep, error flag and both egress streams.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_in_ready  <= 1'b1;
            pkt_out_valid <= 1'b0;
            out_pkt       <= '0;
            out_valid     <= 1'b0;
            out_ts        <= '0;
            out_addr      <= '0;
            out_spike     <= 1'b0;
            out_last      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            cnt           <= '0;
            ts            <= '0;
            bcast_idx     <= '0;
            for (int i = 0; i < NPTR; i++) begin
                ptr[i] <= ADDR_W'(i);
            end
        end else begin
            pkt_in_ready <= (state_nxt == ST_RUN) && (32'(cnt_nxt) != MAP);
            done         <= (state_nxt == ST_DONE);
            cnt          <= cnt_nxt;
            if (acc && !store_ok && !is_req) begin
                err <= 1'b1;
            end
            if (store_ok) begin
                ptr[spe] <= ptr[spe] + ADDR_W'(NUM_SPE);
            end
            case (state)
                ST_RUN: begin
                    if (is_req) begin
                        pkt_out_valid <= 1'b1;
                        out_pkt       <= '{dest: {1'b0, spe}, opcode: in_op,
                                           data: DATA_W'(reply_res)};
                    end else if (complete && (ts != TS_LAST)) begin
                        pkt_out_valid <= 1'b1;
                        out_pkt       <= '{dest: 4'd0, opcode: OP_TS_DONE, data: '0};
                        bcast_idx     <= '0;
                    end
                end
                ST_REPLY: begin
                    if (pkt_xfer) begin
                        pkt_out_valid <= 1'b0;
                    end
                end
                ST_BCAST: begin
                    if (pkt_xfer) begin
                        if (bcast_last) begin
                            pkt_out_valid <= 1'b0;
                            ts            <= ts + TS_W'(1);
                            for (int i = 0; i < NPTR; i++) begin
                                ptr[i] <= ADDR_W'(i);
                            end
                        end else begin
                            bcast_idx    <= bcast_idx + 4'd1;
                            out_pkt.dest <= bcast_idx + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_xfer && last_beat) begin
                        out_valid <= 1'b0;
                    end else if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        out_ts    <= dr_ts;
                        out_addr  <= dr_addr;
                        out_spike <= dr_data[SUM_WIDTH];
                        out_last  <= (32'(dr_addr) == MAP - 1);
                    end
                end
                ST_DONE: begin
                    ts <= '0;
                    for (int i = 0; i < NPTR; i++) begin
                        ptr[i] <= ADDR_W'(i);
                    end
                end
                default: begin
                    pkt_out_valid <= 1'b0;
                    out_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule
